// File: rtl/bp_pkg.sv
// Shared types and constants for branch-predictor blocks built on 2-bit counters.
package bp_pkg;

  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t CTR_SNT = 2'b00;
  localparam pht_ctr_t CTR_WNT = 2'b01;
  localparam pht_ctr_t CTR_WT  = 2'b10;
  localparam pht_ctr_t CTR_ST  = 2'b11;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } pht_state_e;

endpackage

// File: rtl/sat_ctr2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_ctr2
  import bp_pkg::*;
(
  input  pht_ctr_t ctr,
  input  logic     taken,
  output pht_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'b01;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'b01;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC ^ history indexing, registered prediction,
// EX-side training, and a post-reset walk that seeds every entry weakly-not-taken.
module gshare_pht
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned INDEX_BITS   = 10,
  parameter int unsigned HISTORY_BITS = 10,
  parameter int unsigned STAT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pred_req,
  input  logic [ADDR_WIDTH-1:0]   pred_pc,
  input  logic [HISTORY_BITS-1:0] pred_ghr,
  output logic                    pred_ready,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [INDEX_BITS-1:0]   pred_index,
  input  logic                    upd_valid,
  input  logic [INDEX_BITS-1:0]   upd_index,
  input  logic                    upd_taken,
  input  logic                    upd_mispredict,
  output logic [STAT_WIDTH-1:0]   stat_branches,
  output logic [STAT_WIDTH-1:0]   stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  pht_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0]  ptr_q, ptr_d;
  pht_ctr_t               pht_q [ENTRIES];
  logic                   ready_q, valid_q, taken_q;
  logic [INDEX_BITS-1:0]  index_q;
  logic [STAT_WIDTH-1:0]  branches_q, mispredicts_q;

  logic [INDEX_BITS-1:0]  ghr_ext;
  logic [INDEX_BITS-1:0]  pred_idx;
  logic                   pred_fire, upd_fire;
  pht_ctr_t               upd_next;
  logic                   unused_pc;

  assign unused_pc = ^{pred_pc[ADDR_WIDTH-1:INDEX_BITS+2], pred_pc[1:0]};

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HISTORY_BITS-1:0] = pred_ghr;
  end

  assign pred_idx  = pred_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign pred_fire = (state_q == READY) && pred_req;
  assign upd_fire  = (state_q == READY) && upd_valid;

  sat_ctr2 u_upd_ctr (
    .ctr      (pht_q[upd_index]),
    .taken    (upd_taken),
    .ctr_next (upd_next)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + INDEX_BITS'(1);
      if (ptr_q == '1) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      ptr_q         <= '0;
      ready_q       <= 1'b0;
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      index_q       <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == READY);
      valid_q <= pred_fire;
      // Read-before-write: a same-cycle update to this entry lands after the read.
      if (pred_fire) begin
        taken_q <= pht_q[pred_idx][1];
        index_q <= pred_idx;
      end
      if (upd_fire) begin
        if (branches_q != '1) branches_q <= branches_q + STAT_WIDTH'(1);
        if (upd_mispredict && (mispredicts_q != '1))
          mispredicts_q <= mispredicts_q + STAT_WIDTH'(1);
      end
    end
  end

  // Table itself carries no reset; the INIT walk seeds it instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) pht_q[ptr_q] <= CTR_WNT;
      else if (upd_valid)  pht_q[upd_index] <= upd_next;
    end
  end

  assign pred_ready       = ready_q;
  assign pred_valid       = valid_q;
  assign pred_taken       = taken_q;
  assign pred_index       = index_q;
  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed scoreboard bench for gshare_pht with a 16-entry table and 3-bit stats.
module tb_gshare_pht;

  localparam int unsigned AW = 32;
  localparam int unsigned IB = 4;
  localparam int unsigned HB = 4;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_req;
  logic [AW-1:0] pred_pc;
  logic [HB-1:0] pred_ghr;
  logic          pred_ready, pred_valid, pred_taken;
  logic [IB-1:0] pred_index;
  logic          upd_valid, upd_taken, upd_mispredict;
  logic [IB-1:0] upd_index;
  logic [SW-1:0] stat_branches, stat_mispredicts;

  gshare_pht #(
    .ADDR_WIDTH   (AW),
    .INDEX_BITS   (IB),
    .HISTORY_BITS (HB),
    .STAT_WIDTH   (SW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_req         (pred_req),
    .pred_pc          (pred_pc),
    .pred_ghr         (pred_ghr),
    .pred_ready       (pred_ready),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_index       (pred_index),
    .upd_valid        (upd_valid),
    .upd_index        (upd_index),
    .upd_taken        (upd_taken),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          taken;
    logic [IB-1:0] index;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented prediction is matched against the oldest expectation.
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_pred: got idx %0h taken %0b expected none", pred_index, pred_taken);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pred_index", 32'(pred_index), 32'(e.index));
        check("pred_taken", 32'(pred_taken), 32'(e.taken));
      end
    end
  end

  task automatic idle_inputs();
    pred_req = 1'b0; pred_pc = '0; pred_ghr = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  // One clock of stimulus; inputs return to idle just after the edge.
  task automatic drive_cycle(input logic req, input logic [AW-1:0] pc, input logic [HB-1:0] ghr,
                             input logic uv, input logic [IB-1:0] ui, input logic ut, input logic um);
    pred_req = req; pred_pc = pc; pred_ghr = ghr;
    upd_valid = uv; upd_index = ui; upd_taken = ut; upd_mispredict = um;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic predict(input logic [AW-1:0] pc, input logic [HB-1:0] ghr,
                         input logic exp_taken, input logic [IB-1:0] exp_idx);
    exp_q.push_back('{taken: exp_taken, index: exp_idx});
    drive_cycle(1'b1, pc, ghr, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [IB-1:0] idx, input logic taken, input logic mis);
    drive_cycle(1'b0, '0, '0, 1'b1, idx, taken, mis);
  endtask

  task automatic wait_ready(input string name);
    int cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (pred_ready !== 1'b1 && cnt < 100);
    check(name, 32'(cnt), 32'd16);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 32'(pred_ready), 32'd0);
    check("rst_valid", 32'(pred_valid), 32'd0);
    check("rst_index", 32'(pred_index), 32'd0);
    check("rst_branches", 32'(stat_branches), 32'd0);
    check("rst_mispredicts", 32'(stat_mispredicts), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("init_cycles");

    predict(32'h0, 4'h0, 1'b0, 4'h0);

    update(4'd5, 1'b1, 1'b0);
    update(4'd5, 1'b1, 1'b0);
    @(negedge clk);
    check("branches_after_2", 32'(stat_branches), 32'd2);
    predict(32'h14, 4'h0, 1'b1, 4'd5);

    repeat (4) update(4'd5, 1'b0, 1'b0);
    repeat (3) update(4'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("branches_sat_nomis", 32'(stat_branches), 32'd7);
    check("mispredicts_zero", 32'(stat_mispredicts), 32'd0);
    predict(32'h14, 4'h0, 1'b0, 4'd5);
    // one taken step from the floor must still predict not-taken
    update(4'd5, 1'b1, 1'b0);
    predict(32'h14, 4'h0, 1'b0, 4'd5);

    predict(32'h3C, 4'b0101, 1'b0, 4'b1010);

    exp_q.push_back('{taken: 1'b0, index: 4'd7});
    drive_cycle(1'b1, 32'h1C, 4'h0, 1'b1, 4'd7, 1'b1, 1'b0);
    predict(32'h1C, 4'h0, 1'b1, 4'd7);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_valid", 32'(pred_valid), 32'd0);
    check("hold_index", 32'(pred_index), 32'd7);
    check("hold_taken", 32'(pred_taken), 32'd1);

    // reset pulse partway through INIT restarts the walk
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("midinit_not_ready", 32'(pred_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    upd_valid = 1'b1; upd_index = 4'd3; upd_taken = 1'b1; upd_mispredict = 1'b1;
    wait_ready("reinit_cycles");
    idle_inputs();
    @(negedge clk);
    check("init_drop_branches", 32'(stat_branches), 32'd0);
    check("init_drop_mispredicts", 32'(stat_mispredicts), 32'd0);
    predict(32'h0C, 4'h0, 1'b0, 4'd3);
    drive_cycle(1'b0, '0, '0, 1'b1, 4'd3, 1'b1, 1'b0);
    predict(32'h0C, 4'h0, 1'b1, 4'd3);
    predict(32'h1C, 4'h0, 1'b0, 4'd7);

    // clear stats, then drive saturation
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("third_init_cycles");
    repeat (6) update(4'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("branches_6", 32'(stat_branches), 32'd6);
    check("mispredicts_6", 32'(stat_mispredicts), 32'd6);
    repeat (3) update(4'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("branches_sat", 32'(stat_branches), 32'd7);
    check("mispredicts_sat", 32'(stat_mispredicts), 32'd7);
    predict(32'h0, 4'h0, 1'b1, 4'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
